pixel_weigh: RTL and testbench

//   Upstream feed for the per-frame brightness accumulator. Converts the incoming
//   RGB pixel stream into a 3-bit per-pixel brightness weight (wd_o) and a pixel

---
 rtl/pixel_weigh.sv | 134 +++++++++++++
 tb/tb_pixel_weigh.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_weigh.sv
// Pixel brightness weigher: turns an RGB stream into a 3-bit weight with a matching
// pixel enable, and issues one end-of-frame strobe after the frame's last weight
// has left the pipeline.
module pixel_weigh #(
  parameter bit          VS_POL  = 1'b1,
  parameter int unsigned MIN_PIX = 1024,
  parameter int unsigned CNT_W   = 24
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       de_i,
  input  logic       vs_i,
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  output logic       de_o,
  output logic [2:0] wd_o,
  output logic       freeze_o,
  output logic       short_o
);

  localparam logic [CNT_W-1:0] MinPix = CNT_W'(MIN_PIX);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StSync, StActive, StFlush, StFire} state_e;

  state_e           state_q, state_d;
  logic [1:0]       flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             freeze_q, freeze_d;
  logic             short_q, short_d;

  logic [10:0]      y_sum_d, y_sum_q;
  logic             de1_q;
  logic             de_o_q;
  logic [2:0]       wd_q;
  logic             vsa, vsa_q, rise;

  // Luma-like sum 2r + 5g + b; max 2040 fits in 11 bits.
  always_comb begin
    y_sum_d = {2'b00, r_i, 1'b0} + ({3'b000, g_i} << 2) + {3'b000, g_i} + {3'b000, b_i};
  end

  assign vsa  = (vs_i == VS_POL);
  assign rise = vsa & ~vsa_q;

  // Two-stage weight pipeline and vsync edge register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_sum_q <= '0;
      de1_q   <= 1'b0;
      de_o_q  <= 1'b0;
      wd_q    <= '0;
      vsa_q   <= 1'b0;
    end else begin
      y_sum_q <= y_sum_d;
      de1_q   <= de_i;
      de_o_q  <= de1_q;
      wd_q    <= de1_q ? 3'(y_sum_q >> 8) : 3'd0;
      vsa_q   <= vsa;
    end
  end

  // Frame FSM state, counters and registered strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StSync;
      flush_q  <= '0;
      cnt_q    <= '0;
      freeze_q <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      cnt_q    <= cnt_d;
      freeze_q <= freeze_d;
      short_q  <= short_d;
    end
  end

  // Next-state logic. The FIRE decision is taken one cycle early, looking at de1_q
  // (next cycle's de_o), so the strobe can be registered and still never overlap de_o.
  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    cnt_d    = cnt_q;
    freeze_d = 1'b0;
    short_d  = 1'b0;
    unique case (state_q)
      StSync: begin
        // First edge after reset only opens a frame; earlier pixels are a partial frame.
        if (rise) begin
          state_d = StActive;
          cnt_d   = '0;
        end
      end
      StActive: begin
        if (rise) begin
          state_d = StFlush;
          flush_d = 2'd2;
        end else if (de_i && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StFlush: begin
        if (flush_q != 2'd0) begin
          flush_d = flush_q - 2'd1;
        end
        // Malformed de during vsync holds us here until the pipeline drains.
        if ((flush_q <= 2'd1) && !de1_q) begin
          state_d = StFire;
          if (cnt_q >= MinPix) begin
            freeze_d = 1'b1;
          end else begin
            short_d = 1'b1;
          end
        end
      end
      StFire: begin
        state_d = StActive;
        cnt_d   = '0;
      end
      default: begin
        state_d = StSync;
      end
    endcase
  end

  assign de_o     = de_o_q;
  assign wd_o     = wd_q;
  assign freeze_o = freeze_q;
  assign short_o  = short_q;

endmodule

// File: tb/tb_pixel_weigh.sv
// Directed bench for pixel_weigh: scoreboard queues for the pixel pipeline and
// for end-of-frame strobes, plus a negative-vsync instance for polarity checks.
module tb_pixel_weigh;

  logic       clk_i = 1'b0;
  logic       rst_i, rst2;
  logic       de_i, vs_drv, vs_n;
  logic [7:0] r_i, g_i, b_i;
  logic       de_o, freeze_o, short_o;
  logic [2:0] wd_o;
  logic       de2_o, freeze2_o, short2_o;
  logic [2:0] wd2_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rise_cyc = -100;
  int last_de  = -100;
  logic vs_prev = 1'b0;
  int fz2_cnt = 0;
  int sh2_cnt = 0;

  typedef struct {int due; logic de; logic [2:0] wd;} pix_t;
  typedef struct {int due; int kind;} fz_t;  // kind 1 = freeze, 2 = short
  pix_t pix_q[$];
  fz_t  fz_q[$];

  assign vs_n = ~vs_drv;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  pixel_weigh #(.VS_POL(1'b1), .MIN_PIX(1024), .CNT_W(24)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .de_i(de_i), .vs_i(vs_drv),
    .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .de_o(de_o), .wd_o(wd_o), .freeze_o(freeze_o), .short_o(short_o)
  );

  pixel_weigh #(.VS_POL(1'b0), .MIN_PIX(1024), .CNT_W(24)) u_neg (
    .clk_i(clk_i), .rst_i(rst2), .de_i(de_i), .vs_i(vs_n),
    .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .de_o(de2_o), .wd_o(wd2_o), .freeze_o(freeze2_o), .short_o(short2_o)
  );

  function automatic logic [2:0] ref_w(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
    int s;
    s = 2 * int'(r) + 5 * int'(g) + int'(b);
    return 3'(s / 256);
  endfunction

  // Drive one cycle of inputs and queue the pipeline result due two cycles later.
  task automatic step(input logic de, input logic vs, input logic [7:0] r,
                      input logic [7:0] g, input logic [7:0] b);
    pix_t e;
    @(posedge clk_i);
    #1;
    de_i = de; vs_drv = vs; r_i = r; g_i = g; b_i = b;
    if (vs && !vs_prev) rise_cyc = cyc;
    vs_prev = vs;
    if (de) last_de = cyc;
    e.due = cyc + 2;
    e.de  = de;
    e.wd  = de ? ref_w(r, g, b) : 3'd0;
    pix_q.push_back(e);
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic push_strobe(input int kind);
    fz_t f;
    f.due  = (rise_cyc + 3 > last_de + 3) ? rise_cyc + 3 : last_de + 3;
    f.kind = kind;
    fz_q.push_back(f);
  endtask

  // vsync pulse; kind 0 means no strobe expected.
  task automatic vs_pulse(input int kind);
    step(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    if (kind != 0) push_strobe(kind);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    blank(2);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1; de_i = 1'b0; vs_drv = 1'b0; vs_prev = 1'b0;
    pix_q.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    n_tests++;
    assert (de_o === 1'b0) else begin
      n_fail++; $error("FAIL rst_de_o got=%b exp=0", de_o);
    end
    n_tests++;
    assert (wd_o === 3'd0) else begin
      n_fail++; $error("FAIL rst_wd_o got=%0d exp=0", wd_o);
    end
    n_tests++;
    assert (freeze_o === 1'b0) else begin
      n_fail++; $error("FAIL rst_freeze_o got=%b exp=0", freeze_o);
    end
    n_tests++;
    assert (short_o === 1'b0) else begin
      n_fail++; $error("FAIL rst_short_o got=%b exp=0", short_o);
    end
  endtask

  task automatic monitor();
    pix_t e;
    fz_t  f;
    logic [1:0] exp_bits;
    forever begin
      @(negedge clk_i);
      if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
        e = pix_q.pop_front();
        n_tests++;
        assert ({de_o, wd_o} === {e.de, e.wd}) else begin
          n_fail++;
          $error("FAIL pix cyc=%0d got de=%b wd=%0d exp de=%b wd=%0d",
                 cyc, de_o, wd_o, e.de, e.wd);
        end
      end
      exp_bits = 2'b00;
      if (fz_q.size() > 0 && fz_q[0].due == cyc) begin
        f = fz_q.pop_front();
        exp_bits = (f.kind == 1) ? 2'b10 : 2'b01;
      end
      if (freeze_o === 1'b1 || short_o === 1'b1 || exp_bits != 2'b00) begin
        n_tests++;
        assert ({freeze_o, short_o} === exp_bits) else begin
          n_fail++;
          $error("FAIL strobe cyc=%0d got freeze/short=%b exp=%b", cyc,
                 {freeze_o, short_o}, exp_bits);
        end
      end
      if (freeze_o === 1'b1) begin
        n_tests++;
        assert (de_o === 1'b0) else begin
          n_fail++; $error("FAIL overlap cyc=%0d de_o=%b exp=0", cyc, de_o);
        end
      end
      if (freeze2_o === 1'b1) fz2_cnt++;
      if (short2_o === 1'b1) sh2_cnt++;
    end
  endtask

  initial begin
    int v;
    rst_i = 1'b1; rst2 = 1'b1; de_i = 1'b0; vs_drv = 1'b0;
    r_i = '0; g_i = '0; b_i = '0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk_i);
    do_reset();

    // Weight extremes and de gating (FSM still in sync-hunt).
    step(1'b1, 1'b0, 8'd255, 8'd255, 8'd255);
    step(1'b1, 1'b0, 8'd0,   8'd255, 8'd0);
    step(1'b0, 1'b0, 8'd255, 8'd255, 8'd255);
    step(1'b1, 1'b0, 8'd0,   8'd0,   8'd0);
    step(1'b1, 1'b0, 8'd255, 8'd0,   8'd0);
    step(1'b1, 1'b0, 8'd0,   8'd0,   8'd255);
    pixels(6);
    blank(3);

    // First rise only opens a frame; then a full frame freezes.
    vs_pulse(0);
    pixels(2000);
    blank(4);
    vs_pulse(1);

    // Short frame, then the count boundary on both sides.
    pixels(500);
    blank(4);
    vs_pulse(2);
    pixels(1024);
    blank(4);
    vs_pulse(1);
    pixels(1023);
    blank(4);
    vs_pulse(2);

    // de held across the vsync edge defers the freeze.
    pixels(1100);
    step(1'b1, 1'b1, 8'd10, 8'd20, 8'd30);
    v = rise_cyc;
    step(1'b1, 1'b1, 8'd40, 8'd50, 8'd60);
    step(1'b1, 1'b1, 8'd70, 8'd80, 8'd90);
    push_strobe(1);
    n_tests++;
    assert (fz_q[fz_q.size()-1].due === v + 5) else begin
      n_fail++; $error("FAIL defer_due got=%0d exp=%0d", fz_q[fz_q.size()-1].due, v + 5);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    blank(2);

    // Reset mid-frame discards the frame and returns to sync-hunt.
    pixels(300);
    do_reset();
    vs_pulse(0);
    pixels(1100);
    blank(3);
    vs_pulse(1);

    // Negative-polarity instance: sync frame then three full frames.
    @(posedge clk_i);
    #1;
    n_tests++;
    assert ({de2_o, freeze2_o, short2_o} === 3'b000) else begin
      n_fail++; $error("FAIL neg_rst got=%b exp=000", {de2_o, freeze2_o, short2_o});
    end
    fz2_cnt = 0;
    sh2_cnt = 0;
    rst2 = 1'b0;
    blank(2);
    vs_pulse(2);
    for (int f = 0; f < 3; f++) begin
      pixels(4096);
      blank(4);
      vs_pulse(1);
    end
    blank(6);

    n_tests++;
    assert (fz2_cnt === 3) else begin
      n_fail++; $error("FAIL neg_freeze_count got=%0d exp=3", fz2_cnt);
    end
    n_tests++;
    assert (sh2_cnt === 0) else begin
      n_fail++; $error("FAIL neg_short_count got=%0d exp=0", sh2_cnt);
    end
    n_tests++;
    assert (fz_q.size() === 0) else begin
      n_fail++; $error("FAIL strobe_pending got=%0d exp=0", fz_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
